// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the data memory unit: access
//               size encoding, access FSM state encoding, byte-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access size as carried on the size port (log2 of the byte count)
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } access_size_t;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane steering. Merges store bytes into the
//               addressed lane of a storage word, and extracts/extends the
//               addressed lane of a storage word for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import mem_pkg::*;
#(
    parameter int WORD = 64
) (
    input  logic [1:0]                  size,
    input  logic                        sign_ext,
    input  logic [$clog2(WORD/8)-1:0]   lane,
    input  logic [WORD-1:0]             store_data,
    input  logic [WORD-1:0]             mem_word,
    output logic [WORD-1:0]             merged_word,
    output logic [WORD-1:0]             load_data
);

    localparam int BPW = WORD / 8;

    logic [WORD-1:0] w_mask;
    logic [WORD-1:0] w_store_shift;
    logic [WORD-1:0] w_load_shift;

    // Bit mask covering only the bytes this store touches
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < BPW; i++) begin
            if ((i >= int'(lane)) && (i < int'(lane) + int'(bytes_of(size)))) begin
                w_mask[i*8 +: 8] = 8'hFF;
            end
        end
    end

    assign w_store_shift = store_data << {lane, 3'b000};
    assign merged_word   = (w_store_shift & w_mask) | (mem_word & ~w_mask);

    assign w_load_shift  = mem_word >> {lane, 3'b000};

    // Narrow loads are zero- or sign-extended; full-width loads pass through
    always_comb begin
        load_data = w_load_shift;
        case (access_size_t'(size))
            SZ_B:    load_data = {{(WORD-8){sign_ext & w_load_shift[7]}}, w_load_shift[7:0]};
            SZ_H:    load_data = {{(WORD-16){sign_ext & w_load_shift[15]}}, w_load_shift[15:0]};
            SZ_W:    load_data = {{(WORD-32){sign_ext & w_load_shift[31]}}, w_load_shift[31:0]};
            default: load_data = w_load_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit
// Description : Memory stage with sized little-endian loads/stores, fixed
//               wait-state latency behind a stall handshake, alignment and
//               range fault detection, and B/CBZ/CBNZ branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int    WORD        = 64,
    parameter int    DEPTH_WORDS = 128,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            uncondbranch,
    input  logic            branch,
    input  logic            branch_not,
    input  logic            zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    output logic            pc_src,
    output logic [WORD-1:0] read_data,
    output logic            stall,
    output logic            misaligned,
    output logic            out_of_range
);

    localparam int BYTES  = DEPTH_WORDS * WORD / 8;
    localparam int LANE_W = $clog2(WORD / 8);
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int AW     = WORD + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY);
    localparam logic [AW-1:0]    LIMIT_END = AW'(BYTES);

    mem_state_t                  r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [LANE_W+IDX_W-1:0]     r_addr;
    logic [WORD-1:0]             r_wdata;
    access_size_t                r_size;
    logic                        r_sign;
    logic                        r_is_write;
    logic                        r_mis_pend;
    logic                        r_oor_pend;
    logic [WORD-1:0]             r_read_data;
    logic                        r_misaligned;
    logic                        r_out_of_range;
    logic [WORD-1:0]             r_mem [DEPTH_WORDS];

    logic                        w_op;
    logic                        w_mis;
    logic                        w_oor;
    logic [WORD-1:0]             w_align_mask;
    logic [AW-1:0]               w_end;
    logic [IDX_W-1:0]            w_idx;
    logic [LANE_W-1:0]           w_lane;
    logic [WORD-1:0]             w_mem_word;
    logic [WORD-1:0]             w_merged;
    logic [WORD-1:0]             w_load_data;
    logic                        w_commit;

    // Storage starts all zero
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = '0;
    end

    assign pc_src = uncondbranch | (branch & (zero ^ branch_not));

    assign w_op  = mem_read | mem_write;
    assign stall = w_op & (r_state != DONE);

    // Fault checks on the live address; only consulted at acceptance in IDLE
    assign w_align_mask = WORD'(bytes_of(size)) - WORD'(1);
    assign w_mis        = |(address & w_align_mask);
    assign w_end        = {1'b0, address} + AW'(bytes_of(size));
    assign w_oor        = w_end > LIMIT_END;

    assign w_lane     = r_addr[LANE_W-1:0];
    assign w_idx      = r_addr[LANE_W +: IDX_W];
    assign w_mem_word = r_mem[w_idx];
    assign w_commit   = (r_state == BUSY) && (r_cnt == '0);

    load_store_align #(
        .WORD (WORD)
    ) u_align (
        .size        (r_size),
        .sign_ext    (r_sign),
        .lane        (w_lane),
        .store_data  (r_wdata),
        .mem_word    (w_mem_word),
        .merged_word (w_merged),
        .load_data   (w_load_data)
    );

    // Access sequencer: accept, wait out the latency, commit, report
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_size         <= SZ_B;
            r_sign         <= 1'b0;
            r_is_write     <= 1'b0;
            r_mis_pend     <= 1'b0;
            r_oor_pend     <= 1'b0;
            r_read_data    <= '0;
            r_misaligned   <= 1'b0;
            r_out_of_range <= 1'b0;
        end else begin
            r_misaligned   <= 1'b0;
            r_out_of_range <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        r_addr     <= address[LANE_W+IDX_W-1:0];
                        r_wdata    <= write_data;
                        r_size     <= access_size_t'(size);
                        r_sign     <= sign_ext;
                        r_is_write <= mem_write;
                        r_mis_pend <= w_mis;
                        r_oor_pend <= w_oor;
                        if (w_mis || w_oor) begin
                            r_state <= FAULT;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // A store (including read+write) leaves read_data untouched
                        if (!r_is_write) r_read_data <= w_load_data;
                        r_state <= DONE;
                    end
                end
                FAULT: begin
                    r_misaligned   <= r_mis_pend;
                    r_out_of_range <= r_oor_pend;
                    r_read_data    <= '0;
                    r_state        <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Storage write port; only non-faulted stores ever reach BUSY
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write) r_mem[w_idx] <= w_merged;
    end

    assign read_data    = r_read_data;
    assign misaligned   = r_misaligned;
    assign out_of_range = r_out_of_range;

endmodule
`default_nettype wire
